// File: rtl/path_scan_ctrl_pkg.sv
// Shared definitions for the path scan scheduler.
//   scan_state_t    : FSM state encoding
//   DEF_SETTLE_CYC  : default cycles waited after a select change
//   DEF_TIMEOUT_CYC : default cycles waited for a path's finish strobe
package path_scan_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_WAIT_FIN,
        S_CAPTURE,
        S_NEXT,
        S_DONE
    } scan_state_t;

    localparam int unsigned DEF_SETTLE_CYC  = 4;
    localparam int unsigned DEF_TIMEOUT_CYC = 65535;

endpackage

// File: rtl/path_scan_ctrl_if.sv
// Bus between the scan scheduler, the delay-measurement mux and the
// readout/UI logic.
//   master : readout/UI side and mux side (drives start, golden writes, tol,
//            rd_idx, fin_in, result_in)
//   slave  : the scan scheduler (drives sel, status, flags, rd_data)
interface path_scan_ctrl_if #(
    parameter int unsigned NUM_PATHS = 8,
    parameter int unsigned SEL_W     = 3,
    parameter int unsigned RES_W     = 32,
    parameter int unsigned TOL_W     = 16
);
    logic                 start;
    logic [SEL_W-1:0]     sel;
    logic                 fin_in;
    logic [RES_W-1:0]     result_in;
    logic                 gold_we;
    logic [SEL_W-1:0]     gold_idx;
    logic [RES_W-1:0]     gold_data;
    logic [TOL_W-1:0]     tol;
    logic                 busy;
    logic                 done;
    logic [NUM_PATHS-1:0] flag_vec;
    logic [NUM_PATHS-1:0] tmo_vec;
    logic                 trojan;
    logic [SEL_W-1:0]     rd_idx;
    logic [RES_W-1:0]     rd_data;

    modport master (
        output start, fin_in, result_in, gold_we, gold_idx, gold_data, tol, rd_idx,
        input  sel, busy, done, flag_vec, tmo_vec, trojan, rd_data
    );

    modport slave (
        input  start, fin_in, result_in, gold_we, gold_idx, gold_data, tol, rd_idx,
        output sel, busy, done, flag_vec, tmo_vec, trojan, rd_data
    );
endinterface

// File: rtl/path_scan_ctrl_delay_compare.sv
// Combinational deviation check: o_over = |i_a - i_b| > i_tol.
//   i_a, i_b : RES_W-bit counts
//   i_tol    : TOL_W-bit tolerance, zero-extended to RES_W
//   o_over   : deviation strictly exceeds tolerance
module delay_compare #(
    parameter int unsigned RES_W = 32,
    parameter int unsigned TOL_W = 16
) (
    input  logic [RES_W-1:0] i_a,
    input  logic [RES_W-1:0] i_b,
    input  logic [TOL_W-1:0] i_tol,
    output logic             o_over
);
    logic [RES_W-1:0] w_diff;

    // Subtract the smaller from the larger so the magnitude never wraps.
    always_comb begin
        w_diff = (i_a >= i_b) ? (i_a - i_b) : (i_b - i_a);
        o_over = (w_diff > RES_W'(i_tol));
    end
endmodule

// File: rtl/path_scan_ctrl.sv
// Scan scheduler for the 8-way delay-measurement mux. Steps the select code
// through every path, waits for each finish strobe (with timeout), captures
// the delay count and flags paths deviating from their golden count.
//   clk250 : measurement clock
//   rst_n  : asynchronous active-low reset
//   bus    : path_scan_ctrl_if.slave (mux handshake, golden table writes,
//            tolerance, status, flag vectors, capture readback)
module path_scan_ctrl
    import path_scan_ctrl_pkg::*;
#(
    parameter int unsigned NUM_PATHS   = 8,
    parameter int unsigned SEL_W       = 3,
    parameter int unsigned RES_W       = 32,
    parameter int unsigned TOL_W       = 16,
    parameter int unsigned SETTLE_CYC  = DEF_SETTLE_CYC,
    parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic             clk250,
    input  logic             rst_n,
    path_scan_ctrl_if.slave  bus
);
    scan_state_t            r_state;
    scan_state_t            w_state_nxt;
    logic [31:0]            r_cnt;
    logic [SEL_W-1:0]       r_idx;
    logic [TOL_W-1:0]       r_tol;
    logic [NUM_PATHS-1:0]   r_flag;
    logic [NUM_PATHS-1:0]   r_tmo;
    logic                   r_trojan;
    logic [RES_W-1:0]       r_gold [NUM_PATHS];
    logic [RES_W-1:0]       r_cap  [NUM_PATHS];

    logic                   w_scan_start;
    logic                   w_capture;
    logic                   w_timeout;
    logic                   w_last_path;
    logic                   w_over;

    delay_compare #(
        .RES_W (RES_W),
        .TOL_W (TOL_W)
    ) u_cmp (
        .i_a    (bus.result_in),
        .i_b    (r_gold[r_idx]),
        .i_tol  (r_tol),
        .o_over (w_over)
    );

    always_ff @(posedge clk250 or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_scan_start = 1'b0;
        w_capture    = 1'b0;
        w_timeout    = 1'b0;
        w_last_path  = (r_idx == SEL_W'(NUM_PATHS - 1));
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_scan_start = 1'b1;
                    w_state_nxt  = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (r_cnt == SETTLE_CYC - 1) w_state_nxt = S_WAIT_FIN;
            end
            S_WAIT_FIN: begin
                // fin takes priority over an expiring timeout
                if (bus.fin_in) begin
                    w_state_nxt = S_CAPTURE;
                end else if (r_cnt == TIMEOUT_CYC - 1) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = S_NEXT;
                end
            end
            S_CAPTURE: begin
                w_capture   = 1'b1;
                w_state_nxt = S_NEXT;
            end
            S_NEXT:  w_state_nxt = w_last_path ? S_DONE : S_SETTLE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk250 or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_idx    <= '0;
            r_tol    <= '0;
            r_flag   <= '0;
            r_tmo    <= '0;
            r_trojan <= 1'b0;
            for (int unsigned i = 0; i < NUM_PATHS; i++) begin
                r_gold[i] <= '0;
                r_cap[i]  <= '0;
            end
        end else begin
            // Shared settle/timeout counter restarts on every state change.
            r_cnt <= (w_state_nxt != r_state) ? '0 : r_cnt + 32'd1;

            if (w_scan_start) begin
                r_idx    <= '0;
                r_tol    <= bus.tol;
                r_flag   <= '0;
                r_tmo    <= '0;
                r_trojan <= 1'b0;
            end
            if (w_timeout) begin
                r_cap[r_idx]  <= '1;
                r_tmo[r_idx]  <= 1'b1;
                r_flag[r_idx] <= 1'b1;
            end
            if (w_capture) begin
                r_cap[r_idx]  <= bus.result_in;
                r_flag[r_idx] <= w_over;
            end
            // Flags are final by the last NEXT, so trojan is loaded here and
            // is already valid in the cycle done pulses.
            if (r_state == S_NEXT) begin
                if (w_last_path) r_trojan <= |r_flag;
                else             r_idx    <= r_idx + 1'b1;
            end
            if (bus.gold_we && (r_state == S_IDLE)) begin
                r_gold[bus.gold_idx] <= bus.gold_data;
            end
        end
    end

    assign bus.sel      = r_idx;
    assign bus.busy     = (r_state != S_IDLE);
    assign bus.done     = (r_state == S_DONE);
    assign bus.flag_vec = r_flag;
    assign bus.tmo_vec  = r_tmo;
    assign bus.trojan   = r_trojan;
    assign bus.rd_data  = r_cap[bus.rd_idx];
endmodule

// File: tb/tb_path_scan_ctrl.sv
// Self-checking bench for path_scan_ctrl: behavioural mux model, scoreboard of
// expected scan results, directed scan scenarios.
module tb_path_scan_ctrl;
    localparam int unsigned NP  = 8;
    localparam int unsigned SW  = 3;
    localparam int unsigned RW  = 32;
    localparam int unsigned TW  = 16;
    localparam int unsigned TMO = 100;

    logic clk250 = 1'b0;
    logic rst_n  = 1'b0;
    always #2 clk250 = ~clk250;

    path_scan_ctrl_if #(.NUM_PATHS(NP), .SEL_W(SW), .RES_W(RW), .TOL_W(TW)) bus ();

    path_scan_ctrl #(
        .NUM_PATHS   (NP),
        .SEL_W       (SW),
        .RES_W       (RW),
        .TOL_W       (TW),
        .SETTLE_CYC  (4),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk250 (clk250),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    // Mux model: registered fin/result, fin rises m_lat cycles after sel settles.
    logic [RW-1:0]   m_res    [NP];
    int unsigned     m_lat    [NP];
    bit              m_fin_en [NP];
    logic            m_fin    = 1'b0;
    logic [RW-1:0]   m_result = '0;
    logic [SW-1:0]   m_prev_sel = '0;
    int unsigned     m_cnt = 0;

    always @(posedge clk250) begin
        if (bus.sel != m_prev_sel) begin
            m_cnt <= 0;
            m_fin <= 1'b0;
        end else begin
            if (m_cnt < 1000) m_cnt <= m_cnt + 1;
            m_fin <= m_fin_en[bus.sel] && (m_cnt >= m_lat[bus.sel]);
        end
        m_result   <= m_res[bus.sel];
        m_prev_sel <= bus.sel;
    end
    assign bus.fin_in    = m_fin;
    assign bus.result_in = m_result;

    // Monitor: done pulses and sel codes seen while busy.
    int unsigned   done_cnt = 0;
    logic [SW-1:0] sel_seen [$];
    logic          prev_busy = 1'b0;
    logic [SW-1:0] prev_sel  = '0;
    always @(negedge clk250) begin
        if (bus.done === 1'b1) done_cnt++;
        if (bus.busy === 1'b1 && (!prev_busy || bus.sel != prev_sel)) sel_seen.push_back(bus.sel);
        prev_busy <= bus.busy;
        prev_sel  <= bus.sel;
    end

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [NP-1:0]         flags;
        logic [NP-1:0]         tmo;
        logic                  trojan;
        logic [NP-1:0][RW-1:0] cap;
    } exp_t;
    exp_t sb_q [$];

    logic [RW-1:0] g_sh [NP];
    logic [TW-1:0] tol_sh;
    int unsigned   done_base;
    int unsigned   sel_base;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk250);
    endtask

    function automatic exp_t model_scan();
        exp_t e;
        logic [RW-1:0] d;
        e = '0;
        for (int i = 0; i < NP; i++) begin
            if (!m_fin_en[i]) begin
                e.cap[i]   = '1;
                e.tmo[i]   = 1'b1;
                e.flags[i] = 1'b1;
            end else begin
                e.cap[i]   = m_res[i];
                d          = (m_res[i] > g_sh[i]) ? m_res[i] - g_sh[i] : g_sh[i] - m_res[i];
                e.flags[i] = (d > {16'h0, tol_sh});
            end
        end
        e.trojan = |e.flags;
        return e;
    endfunction

    task automatic write_gold(input int i, input logic [RW-1:0] d);
        bus.gold_we   = 1'b1;
        bus.gold_idx  = SW'(i);
        bus.gold_data = d;
        tick();
        bus.gold_we   = 1'b0;
        g_sh[i]       = d;
    endtask

    task automatic begin_scan(input bit expect_result);
        bus.tol   = tol_sh;
        done_base = done_cnt;
        sel_base  = sel_seen.size();
        if (expect_result) sb_q.push_back(model_scan());
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic finish_scan(input string tag);
        exp_t e;
        int unsigned n = 0;
        while (bus.done !== 1'b1 && n < 3000) begin
            tick();
            n++;
        end
        check({tag, "_done_seen"}, 64'(bus.done), 64'd1);
        e = (sb_q.size() != 0) ? sb_q.pop_front() : '0;
        check({tag, "_flag_vec"}, 64'(bus.flag_vec), 64'(e.flags));
        check({tag, "_tmo_vec"},  64'(bus.tmo_vec),  64'(e.tmo));
        check({tag, "_trojan"},   64'(bus.trojan),   64'(e.trojan));
        repeat (3) tick();
        check({tag, "_busy_low"}, 64'(bus.busy), 64'd0);
        check({tag, "_done_pulses"}, 64'(done_cnt - done_base), 64'd1);
        check({tag, "_sel_visits"}, 64'(sel_seen.size() - sel_base), 64'd8);
        for (int i = 0; i < NP; i++) begin
            if (sel_base + i < sel_seen.size())
                check({tag, "_sel_order"}, 64'(sel_seen[sel_base + i]), 64'(i));
            bus.rd_idx = SW'(i);
            #1;
            check({tag, "_rd_data"}, 64'(bus.rd_data), 64'(e.cap[i]));
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_sel"},    64'(bus.sel),      64'd0);
        check({tag, "_busy"},   64'(bus.busy),     64'd0);
        check({tag, "_done"},   64'(bus.done),     64'd0);
        check({tag, "_flag"},   64'(bus.flag_vec), 64'd0);
        check({tag, "_tmo"},    64'(bus.tmo_vec),  64'd0);
        check({tag, "_trojan"}, 64'(bus.trojan),   64'd0);
        for (int i = 0; i < NP; i++) begin
            bus.rd_idx = SW'(i);
            #1;
            check({tag, "_cap"}, 64'(bus.rd_data), 64'd0);
        end
    endtask

    task automatic wait_sel3(input string tag);
        int unsigned n = 0;
        while (bus.sel !== SW'(3) && n < 300) begin
            tick();
            n++;
        end
        check({tag, "_reach_sel3"}, 64'(bus.sel), 64'd3);
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.gold_we   = 1'b0;
        bus.gold_idx  = '0;
        bus.gold_data = '0;
        bus.tol       = '0;
        bus.rd_idx    = '0;
        tol_sh        = '0;
        for (int i = 0; i < NP; i++) begin
            m_res[i]    = RW'(1000 + i);
            m_lat[i]    = i % 3;
            m_fin_en[i] = 1'b1;
            g_sh[i]     = '0;
        end

        repeat (3) tick();
        check_reset_values("rst");
        rst_n = 1'b1;
        tick();

        // All paths within tolerance.
        for (int i = 0; i < NP; i++) write_gold(i, 32'd1000);
        tol_sh = 16'd10;
        begin_scan(1'b1);
        finish_scan("clean");
        check("clean_flag_const", 64'(bus.flag_vec), 64'h00);

        // Path 5 one over tolerance, path 2 exactly at tolerance.
        m_res[5] = 32'd1011;
        m_res[2] = 32'd990;
        begin_scan(1'b1);
        finish_scan("dev");
        check("dev_flag_const",   64'(bus.flag_vec), 64'h20);
        check("dev_trojan_const", 64'(bus.trojan),   64'd1);
        m_res[5] = 32'd1005;
        m_res[2] = 32'd1002;

        // Path 6 never finishes.
        m_fin_en[6] = 1'b0;
        begin_scan(1'b1);
        finish_scan("tmo");
        check("tmo_vec_const", 64'(bus.tmo_vec), 64'h40);
        bus.rd_idx = SW'(6);
        #1;
        check("tmo_rd6_const", 64'(bus.rd_data), 64'hFFFF_FFFF);
        m_fin_en[6] = 1'b1;

        // start, golden write and tol change while busy are all ignored.
        begin_scan(1'b1);
        wait_sel3("busy");
        bus.start     = 1'b1;
        bus.gold_we   = 1'b1;
        bus.gold_idx  = SW'(3);
        bus.gold_data = 32'd5000;
        bus.tol       = '0;
        tick();
        bus.start   = 1'b0;
        bus.gold_we = 1'b0;
        finish_scan("busy");
        begin_scan(1'b1);
        finish_scan("gold_kept");

        // Reset mid-scan discards everything, including the golden table.
        begin_scan(1'b0);
        wait_sel3("midrst");
        #1 rst_n = 1'b0;
        #1;
        check_reset_values("midrst");
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < NP; i++) g_sh[i] = '0;
        tick();
        begin_scan(1'b1);
        finish_scan("after_rst");
        check("after_rst_flag_const", 64'(bus.flag_vec), 64'hFF);

        // Full-width difference against a wide tolerance.
        m_res[0] = 32'hFFFF_FFF0;
        tol_sh   = 16'hFFFF;
        begin_scan(1'b1);
        finish_scan("wide");
        check("wide_flag_const", 64'(bus.flag_vec), 64'h01);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
